// File: rtl/z80_bus_responder.sv
//------------------------------------------------------------------------------
// z80_bus_responder
//
// Bridges the T80 external bus onto the internal valid/ready system bus.
// Each Z80 memory or I/O read/write cycle becomes exactly one internal
// request. WAIT_n is held low until the slave completes the request and a
// minimum wait time has elapsed. Read data is returned toward the Z80 and is
// driven while RD_n stays asserted.
//
// Parameters
//   MIN_WAIT   minimum clk cycles wait_n stays low per accepted cycle (0..255)
//   IO_ENABLE  1 = respond to I/O cycles, 0 = ignore I/O cycles
//
// Ports
//   clk, reset                 system clock, asynchronous active-high reset
//   m1_n, mreq_n, iorq_n,
//   rd_n, wr_n, rfsh_n         Z80 control strobes, synchronous to clk
//   a, d_in                    Z80 address and write data
//   d_out, d_oe                read data toward the Z80 and its drive enable
//   wait_n                     Z80 WAIT_n
//   bus_valid, bus_write,
//   bus_io, bus_address,
//   bus_wdata                  internal request (held stable while valid)
//   bus_ready, bus_rdata       internal slave completion and read data
//------------------------------------------------------------------------------
module z80_bus_responder #(
   parameter int unsigned MIN_WAIT  = 0,
   parameter int unsigned IO_ENABLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [15:0] a,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic        wait_n,
   output logic        bus_valid,
   output logic        bus_write,
   output logic        bus_io,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ready,
   input  logic [7:0]  bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD
   } state_t;

   localparam logic [7:0] MIN_WAIT_CNT = 8'(MIN_WAIT);

   state_t      state, state_next;
   logic [7:0]  wait_cnt, wait_cnt_next, wait_cnt_dec;
   logic        abort_q, abort_next;
   logic        write_next, io_next;
   logic [15:0] address_next;
   logic [7:0]  wdata_next, d_out_next;
   logic        valid_next, wait_n_next, d_oe_next;

   logic strobe_rw;
   logic mem_start;
   logic io_start;
   logic aborting;

   assign strobe_rw = !rd_n || !wr_n;
   // Refresh cycles carry mreq_n low but are not accesses.
   assign mem_start = !mreq_n && rfsh_n && strobe_rw;
   // iorq_n together with m1_n is interrupt acknowledge, not an I/O access.
   assign io_start  = (IO_ENABLE != 0) && !iorq_n && m1_n && strobe_rw;

   // Counter saturates at zero so a slow slave never wraps it.
   assign wait_cnt_dec = (wait_cnt != 8'd0) ? wait_cnt - 8'd1 : 8'd0;

   // Once the CPU has dropped its strobes during REQ the request is finished
   // on the internal bus but its result is thrown away.
   assign aborting = abort_q || !strobe_rw;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      abort_next    = abort_q;
      write_next    = bus_write;
      io_next       = bus_io;
      address_next  = bus_address;
      wdata_next    = bus_wdata;
      d_out_next    = d_out;

      unique case (state)
         ST_IDLE: begin
            if (mem_start || io_start) begin
               state_next    = ST_REQ;
               address_next  = a;
               wdata_next    = d_in;
               write_next    = !wr_n;
               io_next       = !mem_start;
               wait_cnt_next = MIN_WAIT_CNT;
               abort_next    = 1'b0;
            end
         end

         ST_REQ: begin
            wait_cnt_next = wait_cnt_dec;
            abort_next    = aborting;
            if (bus_ready) begin
               if (aborting) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_HOLD;
                  if (!bus_write) d_out_next = bus_rdata;
               end
            end
         end

         ST_HOLD: begin
            wait_cnt_next = wait_cnt_dec;
            // Returning to IDLE here means detection restarts one cycle later.
            if (!strobe_rw) state_next = ST_IDLE;
         end

         default: state_next = ST_IDLE;
      endcase

      // Outputs are computed from the next state so they can be registered
      // without adding a cycle of latency.
      valid_next  = (state_next == ST_REQ);
      wait_n_next = !((state_next == ST_REQ) ||
                      ((state_next == ST_HOLD) && (wait_cnt_next != 8'd0)));
      d_oe_next   = (state_next == ST_HOLD) && !write_next && !rd_n;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= 8'd0;
         abort_q     <= 1'b0;
         bus_valid   <= 1'b0;
         bus_write   <= 1'b0;
         bus_io      <= 1'b0;
         bus_address <= 16'h0000;
         bus_wdata   <= 8'h00;
         d_out       <= 8'h00;
         d_oe        <= 1'b0;
         wait_n      <= 1'b1;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_cnt_next;
         abort_q     <= abort_next;
         bus_valid   <= valid_next;
         bus_write   <= write_next;
         bus_io      <= io_next;
         bus_address <= address_next;
         bus_wdata   <= wdata_next;
         d_out       <= d_out_next;
         d_oe        <= d_oe_next;
         wait_n      <= wait_n_next;
      end
   end

endmodule

// File: tb/tb_z80_bus_responder.sv
//------------------------------------------------------------------------------
// tb_z80_bus_responder
//
// Three responders share one Z80 bus and one slave handshake:
//   u_dut_0 : MIN_WAIT=0, IO_ENABLE=1
//   u_dut_4 : MIN_WAIT=4, IO_ENABLE=1
//   u_dut_x : MIN_WAIT=0, IO_ENABLE=0
// Strobe vectors are {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}.
//------------------------------------------------------------------------------
module tb_z80_bus_responder;

   localparam logic [5:0] S_IDLE   = 6'b111111;
   localparam logic [5:0] S_MEM_RD = 6'b101011;
   localparam logic [5:0] S_MEM_WR = 6'b101101;
   localparam logic [5:0] S_IO_RD  = 6'b110011;
   localparam logic [5:0] S_IO_WR  = 6'b110101;
   localparam logic [5:0] S_RFSH   = 6'b101010;
   localparam logic [5:0] S_INTACK = 6'b010011;
   localparam logic [5:0] S_NORW   = 6'b101111;
   localparam logic [35:0] RESET_VEC = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
   logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
   logic [15:0] a = 16'h0000;
   logic [7:0]  d_in = 8'h00;
   logic        bus_ready = 1'b0;
   logic [7:0]  bus_rdata = 8'h00;

   logic [7:0]  d_out_0, d_out_4, d_out_x;
   logic        d_oe_0, d_oe_4, d_oe_x;
   logic        wait_n_0, wait_n_4, wait_n_x;
   logic        bus_valid_0, bus_valid_4, bus_valid_x;
   logic        bus_write_0, bus_write_4, bus_write_x;
   logic        bus_io_0, bus_io_4, bus_io_x;
   logic [15:0] bus_address_0, bus_address_4, bus_address_x;
   logic [7:0]  bus_wdata_0, bus_wdata_4, bus_wdata_x;

   always #5 clk = ~clk;

   z80_bus_responder #(.MIN_WAIT(0), .IO_ENABLE(1)) u_dut_0 (
      .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .d_in(d_in),
      .d_out(d_out_0), .d_oe(d_oe_0), .wait_n(wait_n_0), .bus_valid(bus_valid_0),
      .bus_write(bus_write_0), .bus_io(bus_io_0), .bus_address(bus_address_0),
      .bus_wdata(bus_wdata_0), .bus_ready(bus_ready), .bus_rdata(bus_rdata));

   z80_bus_responder #(.MIN_WAIT(4), .IO_ENABLE(1)) u_dut_4 (
      .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .d_in(d_in),
      .d_out(d_out_4), .d_oe(d_oe_4), .wait_n(wait_n_4), .bus_valid(bus_valid_4),
      .bus_write(bus_write_4), .bus_io(bus_io_4), .bus_address(bus_address_4),
      .bus_wdata(bus_wdata_4), .bus_ready(bus_ready), .bus_rdata(bus_rdata));

   z80_bus_responder #(.MIN_WAIT(0), .IO_ENABLE(0)) u_dut_x (
      .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .d_in(d_in),
      .d_out(d_out_x), .d_oe(d_oe_x), .wait_n(wait_n_x), .bus_valid(bus_valid_x),
      .bus_write(bus_write_x), .bus_io(bus_io_x), .bus_address(bus_address_x),
      .bus_wdata(bus_wdata_x), .bus_ready(bus_ready), .bus_rdata(bus_rdata));

   int tests_run    = 0;
   int tests_failed = 0;

   // Per-operation measurements filled in by run_op.
   int          valid_cnt_0, wlow_cnt_0, doe_cnt_0, wlow_cnt_4, valid_cnt_x;
   logic [15:0] snap_addr;
   logic        snap_write, snap_io;
   logic [7:0]  snap_wdata, dout_at_release;
   bit          have_snap, unstable;

   // RAM slave used by the back-to-back scenario.
   logic [7:0] ram [256];
   int         ram_lat_cnt;
   int         ram_req_cnt;
   localparam int RAM_LAT = 2;

   task automatic set_strobes(input logic [5:0] s);
      {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = s;
   endtask

   // One Z80 cycle: strobes asserted in cycle 0, released at sample point
   // release_at. ready_at = 0 ties bus_ready high, otherwise a one-cycle pulse.
   task automatic run_op(input logic [5:0] strb, input logic [15:0] addr, input logic [7:0] wd,
                         input int ready_at, input logic [7:0] rdat, input int release_at);
      valid_cnt_0 = 0; wlow_cnt_0 = 0; doe_cnt_0 = 0; wlow_cnt_4 = 0; valid_cnt_x = 0;
      have_snap = 1'b0; unstable = 1'b0; dout_at_release = 8'h00;
      a = addr; d_in = wd; set_strobes(strb);
      bus_ready = (ready_at == 0);
      bus_rdata = (ready_at == 0) ? rdat : ~rdat;
      for (int i = 1; i <= release_at + 3; i++) begin
         @(posedge clk); #1;
         if (bus_valid_0) valid_cnt_0++;
         if (!wait_n_0)   wlow_cnt_0++;
         if (d_oe_0)      doe_cnt_0++;
         if (!wait_n_4)   wlow_cnt_4++;
         if (bus_valid_x) valid_cnt_x++;
         if (bus_valid_0 && !have_snap) begin
            have_snap = 1'b1;
            snap_addr = bus_address_0; snap_write = bus_write_0;
            snap_io = bus_io_0; snap_wdata = bus_wdata_0;
         end else if (bus_valid_0 &&
                      ({bus_address_0, bus_write_0, bus_io_0, bus_wdata_0} !==
                       {snap_addr, snap_write, snap_io, snap_wdata})) begin
            unstable = 1'b1;
         end
         if (i == release_at) begin
            dout_at_release = d_out_0;
            set_strobes(S_IDLE);
         end
         bus_ready = (ready_at == 0) || (i == ready_at);
         bus_rdata = ((ready_at == 0) || (i == ready_at)) ? rdat : ~rdat;
      end
      bus_ready = 1'b0;
   endtask

   task automatic test_reset();
      set_strobes(S_IDLE);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({d_out_0, d_oe_0, wait_n_0, bus_valid_0, bus_write_0, bus_io_0, bus_address_0, bus_wdata_0} !== RESET_VEC) begin
         tests_failed++;
         $display("FAIL reset_dut0: got %h, expected %h",
                  {d_out_0, d_oe_0, wait_n_0, bus_valid_0, bus_write_0, bus_io_0, bus_address_0, bus_wdata_0}, RESET_VEC);
      end
      tests_run++;
      if ({d_out_4, d_oe_4, wait_n_4, bus_valid_4, bus_write_4, bus_io_4, bus_address_4, bus_wdata_4} !== RESET_VEC) begin
         tests_failed++;
         $display("FAIL reset_dut4: got %h, expected %h",
                  {d_out_4, d_oe_4, wait_n_4, bus_valid_4, bus_write_4, bus_io_4, bus_address_4, bus_wdata_4}, RESET_VEC);
      end
      tests_run++;
      if ({d_out_x, d_oe_x, wait_n_x, bus_valid_x, bus_write_x, bus_io_x, bus_address_x, bus_wdata_x} !== RESET_VEC) begin
         tests_failed++;
         $display("FAIL reset_dutx: got %h, expected %h",
                  {d_out_x, d_oe_x, wait_n_x, bus_valid_x, bus_write_x, bus_io_x, bus_address_x, bus_wdata_x}, RESET_VEC);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mem_read();
      run_op(S_MEM_RD, 16'h0010, 8'h00, 3, 8'h5A, 6);
      tests_run++; if (valid_cnt_0 !== 3) begin tests_failed++; $display("FAIL mem_rd_valid_cycles: got %0d, expected 3", valid_cnt_0); end
      tests_run++; if (wlow_cnt_0 !== 3) begin tests_failed++; $display("FAIL mem_rd_wait_cycles: got %0d, expected 3", wlow_cnt_0); end
      tests_run++; if (wlow_cnt_4 !== 4) begin tests_failed++; $display("FAIL mem_rd_wait_cycles_minwait4: got %0d, expected 4", wlow_cnt_4); end
      tests_run++; if ({snap_addr, snap_write, snap_io} !== {16'h0010, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL mem_rd_request: got addr=%h wr=%b io=%b, expected addr=0010 wr=0 io=0", snap_addr, snap_write, snap_io); end
      tests_run++; if (dout_at_release !== 8'h5A) begin tests_failed++; $display("FAIL mem_rd_data: got %h, expected 5a", dout_at_release); end
      tests_run++; if (doe_cnt_0 !== 3) begin tests_failed++; $display("FAIL mem_rd_doe_cycles: got %0d, expected 3", doe_cnt_0); end
      tests_run++; if (d_oe_0 !== 1'b0) begin tests_failed++; $display("FAIL mem_rd_doe_after: got %b, expected 0", d_oe_0); end
      tests_run++; if (unstable !== 1'b0) begin tests_failed++; $display("FAIL mem_rd_stable: request changed while valid"); end
   endtask

   task automatic test_mem_write();
      run_op(S_MEM_WR, 16'h0015, 8'h11, 0, 8'hEE, 6);
      tests_run++; if ({snap_addr, snap_write, snap_io, snap_wdata} !== {16'h0015, 1'b1, 1'b0, 8'h11}) begin tests_failed++; $display("FAIL mem_wr_request: got addr=%h wr=%b io=%b wdata=%h, expected addr=0015 wr=1 io=0 wdata=11", snap_addr, snap_write, snap_io, snap_wdata); end
      tests_run++; if (wlow_cnt_0 !== 1) begin tests_failed++; $display("FAIL mem_wr_wait_cycles: got %0d, expected 1", wlow_cnt_0); end
      tests_run++; if (valid_cnt_0 !== 1) begin tests_failed++; $display("FAIL mem_wr_valid_cycles: got %0d, expected 1", valid_cnt_0); end
      tests_run++; if (doe_cnt_0 !== 0) begin tests_failed++; $display("FAIL mem_wr_doe: got %0d cycles, expected 0", doe_cnt_0); end
      tests_run++; if (d_out_0 !== 8'h5A) begin tests_failed++; $display("FAIL mem_wr_dout_kept: got %h, expected 5a", d_out_0); end
   endtask

   task automatic test_io();
      run_op(S_IO_WR, 16'h00A8, 8'h22, 0, 8'hEE, 6);
      tests_run++; if ({snap_addr, snap_write, snap_io, snap_wdata} !== {16'h00A8, 1'b1, 1'b1, 8'h22}) begin tests_failed++; $display("FAIL io_wr_request: got addr=%h wr=%b io=%b wdata=%h, expected addr=00a8 wr=1 io=1 wdata=22", snap_addr, snap_write, snap_io, snap_wdata); end
      tests_run++; if (wlow_cnt_4 !== 4) begin tests_failed++; $display("FAIL io_wr_wait_minwait4: got %0d, expected 4", wlow_cnt_4); end
      tests_run++; if (valid_cnt_x !== 0) begin tests_failed++; $display("FAIL io_wr_disabled: got %0d valid cycles, expected 0", valid_cnt_x); end
      @(posedge clk); #1;
      run_op(S_IO_RD, 16'h00A8, 8'h00, 0, 8'h3C, 6);
      tests_run++; if ({snap_addr, snap_write, snap_io} !== {16'h00A8, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL io_rd_request: got addr=%h wr=%b io=%b, expected addr=00a8 wr=0 io=1", snap_addr, snap_write, snap_io); end
      tests_run++; if (wlow_cnt_4 !== 4) begin tests_failed++; $display("FAIL io_rd_wait_minwait4: got %0d, expected 4", wlow_cnt_4); end
      tests_run++; if (dout_at_release !== 8'h3C) begin tests_failed++; $display("FAIL io_rd_data: got %h, expected 3c", dout_at_release); end
      tests_run++; if (doe_cnt_0 !== 5) begin tests_failed++; $display("FAIL io_rd_doe_cycles: got %0d, expected 5", doe_cnt_0); end
      tests_run++; if (valid_cnt_x !== 0) begin tests_failed++; $display("FAIL io_rd_disabled: got %0d valid cycles, expected 0", valid_cnt_x); end
   endtask

   task automatic test_ignored_cycles();
      logic [5:0] vec [3];
      vec[0] = S_RFSH; vec[1] = S_INTACK; vec[2] = S_NORW;
      for (int k = 0; k < 3; k++) begin
         run_op(vec[k], 16'h1234, 8'h00, 0, 8'h99, 4);
         tests_run++;
         if ({valid_cnt_0, wlow_cnt_0, doe_cnt_0, wlow_cnt_4, valid_cnt_x} !== {32'd0, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL ignored_cycle_%0d: got valid=%0d waitlow=%0d doe=%0d waitlow4=%0d validx=%0d, expected all 0",
                     k, valid_cnt_0, wlow_cnt_0, doe_cnt_0, wlow_cnt_4, valid_cnt_x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_abort();
      run_op(S_MEM_RD, 16'h0020, 8'h00, 4, 8'hC3, 2);
      tests_run++; if (valid_cnt_0 !== 4) begin tests_failed++; $display("FAIL abort_valid_cycles: got %0d, expected 4", valid_cnt_0); end
      tests_run++; if (doe_cnt_0 !== 0) begin tests_failed++; $display("FAIL abort_doe: got %0d cycles, expected 0", doe_cnt_0); end
      tests_run++; if (d_out_0 !== 8'h3C) begin tests_failed++; $display("FAIL abort_dout_discarded: got %h, expected 3c", d_out_0); end
      tests_run++; if ({wait_n_0, bus_valid_0} !== 2'b10) begin tests_failed++; $display("FAIL abort_idle: got wait_n=%b valid=%b, expected 1 0", wait_n_0, bus_valid_0); end
   endtask

   task automatic test_reset_mid_req();
      a = 16'h0030; set_strobes(S_MEM_RD); bus_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if ({bus_valid_0, wait_n_0} !== 2'b10) begin tests_failed++; $display("FAIL midreq_precondition: got valid=%b wait_n=%b, expected 1 0", bus_valid_0, wait_n_0); end
      #2 reset = 1'b1;
      #1;
      tests_run++; if ({bus_valid_0, wait_n_0, d_oe_0, d_out_0} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin tests_failed++; $display("FAIL midreq_async_reset: got valid=%b wait_n=%b doe=%b dout=%h, expected 0 1 0 00", bus_valid_0, wait_n_0, d_oe_0, d_out_0); end
      set_strobes(S_IDLE);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if ({bus_valid_0, wait_n_0} !== 2'b01) begin tests_failed++; $display("FAIL midreq_after_reset: got valid=%b wait_n=%b, expected 0 1", bus_valid_0, wait_n_0); end
   endtask

   // RAM slave: completes each request RAM_LAT cycles after valid rises.
   task automatic ram_respond();
      if (bus_valid_0) begin
         if (ram_lat_cnt == RAM_LAT) begin
            bus_ready = 1'b1;
            if (bus_write_0) ram[bus_address_0[7:0]] = bus_wdata_0;
            else             bus_rdata = ram[bus_address_0[7:0]];
            ram_req_cnt++;
            ram_lat_cnt = 0;
         end else begin
            bus_ready = 1'b0;
            ram_lat_cnt++;
         end
      end else begin
         bus_ready = 1'b0;
         ram_lat_cnt = 0;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      ram_respond();
   endtask

   // CPU model that samples wait_n only on clock-enable ticks of the given ratio.
   task automatic cpu_access(input int ratio, input bit is_wr, input logic [15:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output bit timeout);
      bit done;
      done = 1'b0; timeout = 1'b0; rd = 8'hxx;
      a = addr; d_in = wd;
      set_strobes(is_wr ? S_MEM_WR : S_MEM_RD);
      for (int k = 1; k <= ratio * 20 && !done; k++) begin
         step();
         if ((k % ratio) == 0 && wait_n_0) begin
            if (!is_wr) rd = d_oe_0 ? d_out_0 : 8'hxx;
            done = 1'b1;
         end
      end
      if (!done) timeout = 1'b1;
      set_strobes(S_IDLE);
      repeat (ratio) step();
   endtask

   task automatic test_back_to_back();
      int ratios [4];
      logic [7:0] rd;
      bit to0, to1, to2;
      ratios = '{25, 13, 7, 5};
      for (int r = 0; r < 4; r++) begin
         for (int j = 0; j < 256; j++) ram[j] = 8'h00;
         ram_lat_cnt = 0; ram_req_cnt = 0;
         cpu_access(ratios[r], 1'b1, 16'h0010, 8'h11, rd, to0);
         cpu_access(ratios[r], 1'b1, 16'h0011, 8'h00, rd, to1);
         cpu_access(ratios[r], 1'b0, 16'h0010, 8'h00, rd, to2);
         tests_run++; if ({to0, to1, to2} !== 3'b000) begin tests_failed++; $display("FAIL b2b_r%0d_timeout: got %b, expected 000", ratios[r], {to0, to1, to2}); end
         tests_run++; if (rd !== 8'h11) begin tests_failed++; $display("FAIL b2b_r%0d_readback: got %h, expected 11", ratios[r], rd); end
         tests_run++; if (!rd[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_r%0d_zflag: got Z=%b, expected 0", ratios[r], !rd[0]); end
         tests_run++; if (ram_req_cnt !== 3) begin tests_failed++; $display("FAIL b2b_r%0d_requests: got %0d, expected 3", ratios[r], ram_req_cnt); end
      end
      bus_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mem_read();
      @(posedge clk); #1;
      test_mem_write();
      @(posedge clk); #1;
      test_io();
      @(posedge clk); #1;
      test_ignored_cycles();
      test_abort();
      @(posedge clk); #1;
      test_reset_mid_req();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
